// File: rtl/lfsr_seq_checker_if.sv
// Sample stream and status bus between the 3-bit LFSR generator side and its sequence checker.
interface lfsr_seq_checker_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 in_valid;
   logic [2:0]           in_data;
   logic                 clear;
   logic                 locked;
   logic                 err_pulse;
   logic [ERR_CNT_W-1:0] err_count;
   logic                 zero_seen;
   logic [3:0]           period;
   logic                 period_valid;

   modport master (
      output in_valid, in_data, clear,
      input  locked, err_pulse, err_count, zero_seen, period, period_valid
   );

   modport slave (
      input  in_valid, in_data, clear,
      output locked, err_pulse, err_count, zero_seen, period, period_valid
   );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Locks onto a 3-bit LFSR stream, counts mismatches while locked, flags the
// all-zero lock-up value and measures the sequence period between anchor hits.
module lfsr_seq_checker #(
   parameter int LOCK_MATCHES = 2,
   parameter int ERR_CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   lfsr_seq_checker_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, SYNC, LOCKED} state_t;

   state_t               state_reg, state_next;
   logic [2:0]           prev_reg, prev_next;
   logic [2:0]           match_run_reg, match_run_next;
   logic [2:0]           anchor_reg, anchor_next;
   logic [3:0]           since_anchor_reg, since_anchor_next;
   logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;
   logic                 err_pulse_reg, err_pulse_next;
   logic                 zero_seen_reg, zero_seen_next;
   logic [3:0]           period_reg, period_next;
   logic                 period_valid_reg, period_valid_next;

   logic [2:0] predicted;
   logic [2:0] run_inc;
   logic [3:0] since_inc;
   logic       is_match;

   assign predicted = {prev_reg[1], prev_reg[0], prev_reg[0] ^ prev_reg[2]};
   assign is_match  = (bus.in_data == predicted);
   assign run_inc   = match_run_reg + 3'd1;
   assign since_inc = (since_anchor_reg == 4'd15) ? 4'd15 : since_anchor_reg + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= EMPTY;
         prev_reg         <= '0;
         match_run_reg    <= '0;
         anchor_reg       <= '0;
         since_anchor_reg <= '0;
         err_count_reg    <= '0;
         err_pulse_reg    <= 1'b0;
         zero_seen_reg    <= 1'b0;
         period_reg       <= '0;
         period_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         prev_reg         <= prev_next;
         match_run_reg    <= match_run_next;
         anchor_reg       <= anchor_next;
         since_anchor_reg <= since_anchor_next;
         err_count_reg    <= err_count_next;
         err_pulse_reg    <= err_pulse_next;
         zero_seen_reg    <= zero_seen_next;
         period_reg       <= period_next;
         period_valid_reg <= period_valid_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      prev_next         = prev_reg;
      match_run_next    = match_run_reg;
      anchor_next       = anchor_reg;
      since_anchor_next = since_anchor_reg;
      err_count_next    = err_count_reg;
      err_pulse_next    = 1'b0;
      zero_seen_next    = zero_seen_reg;
      period_next       = period_reg;
      period_valid_next = 1'b0;

      if (bus.clear) begin
         state_next        = EMPTY;
         match_run_next    = '0;
         since_anchor_next = '0;
         err_count_next    = '0;
         zero_seen_next    = 1'b0;
         period_next       = '0;
      end else if (bus.in_valid) begin
         prev_next = bus.in_data;
         // All-zero is the LFSR lock-up state: restart without counting an error.
         if (bus.in_data == 3'b000) begin
            zero_seen_next = 1'b1;
            state_next     = EMPTY;
            match_run_next = '0;
         end else begin
            unique case (state_reg)
               EMPTY: begin
                  state_next     = SYNC;
                  match_run_next = '0;
               end
               SYNC: begin
                  if (is_match) begin
                     match_run_next = run_inc;
                     if (run_inc == 3'(LOCK_MATCHES)) begin
                        state_next        = LOCKED;
                        anchor_next       = bus.in_data;
                        since_anchor_next = '0;
                     end
                  end else begin
                     match_run_next = '0;
                  end
               end
               LOCKED: begin
                  if (is_match) begin
                     since_anchor_next = since_inc;
                     if (bus.in_data == anchor_reg) begin
                        period_next       = since_inc;
                        period_valid_next = 1'b1;
                        since_anchor_next = '0;
                     end
                  end else begin
                     err_pulse_next = 1'b1;
                     if (err_count_reg != '1) err_count_next = err_count_reg + 1'b1;
                     state_next     = SYNC;
                     match_run_next = '0;
                  end
               end
               default: state_next = EMPTY;
            endcase
         end
      end
   end

   assign bus.locked       = (state_reg == LOCKED);
   assign bus.err_pulse    = err_pulse_reg;
   assign bus.err_count    = err_count_reg;
   assign bus.zero_seen    = zero_seen_reg;
   assign bus.period       = period_reg;
   assign bus.period_valid = period_valid_reg;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: a reference model queues expected outputs per edge.
module tb_lfsr_seq_checker;
   localparam int LOCK = 2;

   logic clk;
   logic rst;

   lfsr_seq_checker_if #(.ERR_CNT_W(8)) bus ();
   lfsr_seq_checker_if #(.ERR_CNT_W(2)) bus2 ();

   lfsr_seq_checker #(.LOCK_MATCHES(LOCK), .ERR_CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Narrow-counter copy sees the identical stream to show saturation.
   lfsr_seq_checker #(.LOCK_MATCHES(LOCK), .ERR_CNT_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   assign bus2.in_valid = bus.in_valid;
   assign bus2.in_data  = bus.in_data;
   assign bus2.clear    = bus.clear;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       locked;
      logic       ep;
      logic [7:0] err8;
      logic [1:0] err2;
      logic       zero;
      logic [3:0] period;
      logic       pv;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   // Reference model state: st 0=EMPTY 1=SYNC 2=LOCKED
   int m_st, m_run, m_since, m_err8, m_err2, m_period;
   logic [2:0] m_prev, m_anchor;
   logic m_zero, m_ep, m_pv;

   function automatic logic [2:0] nxt(input logic [2:0] x);
      return {x[1], x[0], x[0] ^ x[2]};
   endfunction

   task automatic model_reset();
      m_st = 0; m_run = 0; m_since = 0; m_err8 = 0; m_err2 = 0; m_period = 0;
      m_prev = 3'b000; m_anchor = 3'b000; m_zero = 1'b0; m_ep = 1'b0; m_pv = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [2:0] d, input logic c);
      logic match;
      exp_t e;
      m_ep = 1'b0;
      m_pv = 1'b0;
      if (c) begin
         m_st = 0; m_run = 0; m_since = 0; m_err8 = 0; m_err2 = 0; m_period = 0; m_zero = 1'b0;
      end else if (v) begin
         match = (d == nxt(m_prev));
         if (d == 3'b000) begin
            m_zero = 1'b1; m_st = 0; m_run = 0;
         end else if (m_st == 0) begin
            m_st = 1; m_run = 0;
         end else if (!match) begin
            if (m_st == 2) begin
               m_ep = 1'b1;
               if (m_err8 < 255) m_err8++;
               if (m_err2 < 3) m_err2++;
            end
            m_st = 1; m_run = 0;
         end else if (m_st == 1) begin
            m_run++;
            if (m_run == LOCK) begin
               m_st = 2; m_anchor = d; m_since = 0;
            end
         end else begin
            if (d == m_anchor) begin
               m_period = (m_since + 1 > 15) ? 15 : m_since + 1;
               m_pv = 1'b1;
               m_since = 0;
            end else begin
               m_since = (m_since + 1 > 15) ? 15 : m_since + 1;
            end
         end
         m_prev = d;
      end
      e.locked = (m_st == 2);
      e.ep     = m_ep;
      e.err8   = 8'(m_err8);
      e.err2   = 2'(m_err2);
      e.zero   = m_zero;
      e.period = 4'(m_period);
      e.pv     = m_pv;
      sb.push_back(e);
   endtask

   // One clock of stimulus; returns 1 time unit after the edge.
   task automatic cyc(input logic v, input logic [2:0] d, input logic c);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.clear    = c;
      @(posedge clk);
      model_step(v, d, c);
      #1;
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         vectors++;
         if (bus.locked !== e.locked || bus.err_pulse !== e.ep || bus.err_count !== e.err8 ||
             bus2.err_count !== e.err2 || bus.zero_seen !== e.zero || bus.period !== e.period ||
             bus.period_valid !== e.pv) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got lk=%b ep=%b ec=%0d ec2=%0d z=%b p=%0d pv=%b exp lk=%b ep=%b ec=%0d ec2=%0d z=%b p=%0d pv=%b",
                     $time, bus.locked, bus.err_pulse, bus.err_count, bus2.err_count, bus.zero_seen,
                     bus.period, bus.period_valid, e.locked, e.ep, e.err8, e.err2, e.zero, e.period, e.pv);
         end
      end
   end

   logic [2:0] clean_seq [10];
   initial begin
      clean_seq[0] = 3'b100; clean_seq[1] = 3'b001; clean_seq[2] = 3'b011; clean_seq[3] = 3'b111;
      clean_seq[4] = 3'b110; clean_seq[5] = 3'b101; clean_seq[6] = 3'b010; clean_seq[7] = 3'b100;
      clean_seq[8] = 3'b001; clean_seq[9] = 3'b011;
   end

   task automatic test_reset();
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = 3'b000; bus.clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 3'b000, 1'b0);
         vectors++;
         if (bus.locked !== 1'b0 || bus.err_count !== 8'd0 || bus.zero_seen !== 1'b0 ||
             bus.period !== 4'd0 || bus.err_pulse !== 1'b0 || bus.period_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d got lk=%b ec=%0d z=%b p=%0d ep=%b pv=%b want all 0",
                     i, bus.locked, bus.err_count, bus.zero_seen, bus.period, bus.err_pulse, bus.period_valid);
         end
      end
   endtask

   task automatic test_lock_period();
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, clean_seq[i], 1'b0);
         if (i == 1 || i == 2) begin
            vectors++;
            if (bus.locked !== (i == 2)) begin
               miscompares++;
               $display("FAIL lock_latency sample %0d got locked=%b want %b", i + 1, bus.locked, (i == 2));
            end
         end
         if (i == 8 || i == 9) begin
            vectors++;
            if (bus.period_valid !== (i == 9) || (i == 9 && bus.period !== 4'd7) || bus.err_count !== 8'd0) begin
               miscompares++;
               $display("FAIL period sample %0d got pv=%b period=%0d ec=%0d want pv=%b period=7 ec=0",
                        i + 1, bus.period_valid, bus.period, bus.err_count, (i == 9));
            end
         end
      end
   endtask

   task automatic test_error_inject();
      cyc(1'b1, 3'b110, 1'b0);
      vectors++;
      if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL inject got ep=%b ec=%0d lk=%b want ep=1 ec=1 lk=0", bus.err_pulse, bus.err_count, bus.locked);
      end
      cyc(1'b1, 3'b101, 1'b0);
      vectors++;
      if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL inject_pulse_width got ep=%b lk=%b want ep=0 lk=0", bus.err_pulse, bus.locked);
      end
      cyc(1'b1, 3'b010, 1'b0);
      vectors++;
      if (bus.locked !== 1'b1 || bus.err_count !== 8'd1) begin
         miscompares++;
         $display("FAIL relock got lk=%b ec=%0d want lk=1 ec=1", bus.locked, bus.err_count);
      end
   endtask

   task automatic test_zero_clear();
      cyc(1'b1, 3'b000, 1'b0);
      vectors++;
      if (bus.zero_seen !== 1'b1 || bus.locked !== 1'b0 || bus.err_count !== 8'd1 || bus.err_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL zero got z=%b lk=%b ec=%0d ep=%b want z=1 lk=0 ec=1 ep=0",
                  bus.zero_seen, bus.locked, bus.err_count, bus.err_pulse);
      end
      cyc(1'b0, 3'b000, 1'b0);
      cyc(1'b1, 3'b100, 1'b1);
      vectors++;
      if (bus.zero_seen !== 1'b0 || bus.err_count !== 8'd0 || bus.period !== 4'd0 || bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL clear got z=%b ec=%0d p=%0d lk=%b want all 0", bus.zero_seen, bus.err_count, bus.period, bus.locked);
      end
      // The 100 sent with clear must have been dropped, so 001,011 is only one match.
      cyc(1'b1, 3'b001, 1'b0);
      cyc(1'b1, 3'b011, 1'b0);
      vectors++;
      if (bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_drops_sample got locked=%b want 0", bus.locked);
      end
      cyc(1'b1, 3'b111, 1'b0);
      vectors++;
      if (bus.locked !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_after_clear got locked=%b want 1", bus.locked);
      end
   endtask

   task automatic test_stall_saturate();
      cyc(1'b0, 3'b000, 1'b1);
      for (int ep = 0; ep < 4; ep++) begin
         cyc(1'b1, 3'b001, 1'b0);
         cyc(1'b1, 3'b011, 1'b0);
         cyc(1'b1, 3'b111, 1'b0);
         cyc(1'b1, 3'b110, 1'b0);
         cyc(1'b1, 3'b101, 1'b0);
         cyc(1'b1, 3'b101, 1'b0);
         vectors++;
         if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'(ep + 1)) begin
            miscompares++;
            $display("FAIL stall_err episode %0d got ep=%b ec=%0d want ep=1 ec=%0d", ep, bus.err_pulse, bus.err_count, ep + 1);
         end
         cyc(1'b1, 3'b101, 1'b0);
      end
      vectors++;
      if (bus.err_count !== 8'd4 || bus2.err_count !== 2'd3) begin
         miscompares++;
         $display("FAIL saturate got ec8=%0d ec2=%0d want ec8=4 ec2=3", bus.err_count, bus2.err_count);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, clean_seq[i], 1'b0);
      @(negedge clk);
      #1;
      vectors++;
      if (bus.locked !== 1'b1 || bus.period !== 4'd7) begin
         miscompares++;
         $display("FAIL prereset got lk=%b p=%0d want lk=1 p=7", bus.locked, bus.period);
      end
      rst = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (bus.locked !== 1'b0 || bus.err_count !== 8'd0 || bus.period !== 4'd0 || bus2.err_count !== 2'd0) begin
         miscompares++;
         $display("FAIL async_reset got lk=%b ec=%0d p=%0d ec2=%0d want all 0",
                  bus.locked, bus.err_count, bus.period, bus2.err_count);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      cyc(1'b1, 3'b100, 1'b0);
      cyc(1'b0, 3'b000, 1'b0);
      cyc(1'b1, 3'b001, 1'b0);
      cyc(1'b0, 3'b000, 1'b0);
      cyc(1'b0, 3'b000, 1'b0);
      vectors++;
      if (bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL relock_early got locked=%b want 0", bus.locked);
      end
      cyc(1'b1, 3'b011, 1'b0);
      vectors++;
      if (bus.locked !== 1'b1) begin
         miscompares++;
         $display("FAIL relock_3rd got locked=%b want 1", bus.locked);
      end
   endtask

   initial begin
      test_reset();
      test_lock_period();
      test_error_inject();
      test_zero_clear();
      test_stall_saturate();
      test_async_reset();
      @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
